gpio_port: RTL and testbench

GPIO_PORT -- requirements
Module: gpio_port

---
 rtl/gpio_pkg.sv | 12 +
 rtl/gpio_debounce_bit.sv | 67 ++++++
 rtl/gpio_port.sv | 60 ++++++
 tb/tb_gpio_port.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared defaults and the debounce counter-width helper for the GPIO port.
package gpio_pkg;

    localparam int GPIO_WIDTH_DEF      = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    // Counter must reach DEBOUNCE_CYCLES-1 and never exceed it.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input bit: 2-flop synchronizer, optional debounce (GPIO_DEBOUNCE_EN)
// and a sticky change flag whose set has priority over clear.
module gpio_debounce_bit
    import gpio_pkg::*;
`ifdef GPIO_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    input  logic i_chg_clr,
    output logic o_stable,
    output logic o_chg
);

    logic r_sync1;
    logic r_sync2;
    logic r_stable;
    logic r_chg;
    logic w_accept;

`ifdef GPIO_DEBOUNCE_EN
    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Accept only after the new level has been seen DEBOUNCE_CYCLES edges in a row.
    assign w_accept = (r_sync2 != r_stable) && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if ((r_sync2 == r_stable) || (r_cnt == CNT_MAX)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_accept = (r_sync2 != r_stable);
`endif

    // NOTE: non-blocking assignments let r_sync2 sample the old r_sync1, forming a true 2-stage chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_chg    <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (w_accept) begin
                r_stable <= r_sync2;
            end
            r_chg <= w_accept | (r_chg & ~i_chg_clr);
        end
    end

    assign o_stable = r_stable;
    assign o_chg    = r_chg;

endmodule

// File: rtl/gpio_port.sv
// GPIO port: registered output latch plus WIDTH synchronized/debounced inputs
// with sticky change flags. Debounce is built only when GPIO_DEBOUNCE_EN is defined.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] GPIO_o,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] GPIO_i,
    input  logic             chg_clr_i,
    output logic [WIDTH-1:0] chg_o,
    output logic             chg_any_o
);

    logic [WIDTH-1:0] r_gpio_out;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_chg;

    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 65535)) begin : g_bad_cfg
        $error("gpio_port: DEBOUNCE_CYCLES must be within 2..65535");
    end

    // NOTE: every flop here has async reset; there is no memory array, so nothing is left uninitialised.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gpio_out <= '0;
        end else if (wr_en_i) begin
            r_gpio_out <= wr_data_i;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        gpio_debounce_bit
`ifdef GPIO_DEBOUNCE_EN
        #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        )
`endif
        u_bit (
            .clk       (clk),
            .reset     (reset),
            .i_pin     (pins_i[g]),
            .i_chg_clr (chg_clr_i),
            .o_stable  (w_stable[g]),
            .o_chg     (w_chg[g])
        );
    end

    assign GPIO_o    = r_gpio_out;
    assign GPIO_i    = w_stable;
    assign chg_o     = w_chg;
    assign chg_any_o = |w_chg;

endmodule

// File: tb/tb_gpio_port.sv
// Scoreboard bench for gpio_port: stimulus queues expected values tagged with the
// clock edge they must hold after; a negedge monitor pops and compares them.
module tb_gpio_port;

    localparam int DC = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 2 + DC;
`else
    localparam int LAT = 3;
`endif

    typedef enum logic [1:0] {F_GPIO_O, F_GPIO_I, F_CHG, F_ANY} field_e;

    typedef struct {
        int         at_edge;
        field_e     field;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       wr_en_i;
    logic [7:0] wr_data_i;
    logic [7:0] GPIO_o;
    logic [7:0] pins_i;
    logic [7:0] GPIO_i;
    logic       chg_clr_i;
    logic [7:0] chg_o;
    logic       chg_any_o;

    exp_t       sb_q[$];
    int         edge_cnt = 0;
    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] mon_act;

    gpio_port #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en_i),
        .wr_data_i (wr_data_i),
        .GPIO_o    (GPIO_o),
        .pins_i    (pins_i),
        .GPIO_i    (GPIO_i),
        .chg_clr_i (chg_clr_i),
        .chg_o     (chg_o),
        .chg_any_o (chg_any_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [7:0] sample(input field_e f);
        case (f)
            F_GPIO_O: return GPIO_o;
            F_GPIO_I: return GPIO_i;
            F_CHG:    return chg_o;
            default:  return {7'b0, chg_any_o};
        endcase
    endfunction

    // Monitor: compares every expectation whose edge has arrived.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at_edge <= edge_cnt) begin
                mon_act = sample(sb_q[i].field);
                n_checks++;
                if (sb_q[i].at_edge != edge_cnt) begin
                    n_fails++;
                    $display("FAIL %s missed: due edge %0d, checked at edge %0d",
                             sb_q[i].name, sb_q[i].at_edge, edge_cnt);
                end else if (mon_act !== sb_q[i].val) begin
                    n_fails++;
                    $display("FAIL %s edge=%0d actual=0x%02h expected=0x%02h",
                             sb_q[i].name, edge_cnt, mon_act, sb_q[i].val);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic expect_at(input int k, input field_e f, input logic [7:0] v, input string nm);
        exp_t e;
        e.at_edge = edge_cnt + k;
        e.field   = f;
        e.val     = v;
        e.name    = nm;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        chg_clr_i = 1'b1;
        tick(1);
        chg_clr_i = 1'b0;
    endtask

    typedef struct {
        logic       we;
        logic [7:0] data;
        logic [7:0] exp_out;
    } wr_vec_t;

    wr_vec_t wr_tab[6];

    initial begin
        wr_tab[0] = '{1'b1, 8'hA5, 8'hA5};
        wr_tab[1] = '{1'b0, 8'h3C, 8'hA5};
        wr_tab[2] = '{1'b0, 8'hFF, 8'hA5};
        wr_tab[3] = '{1'b1, 8'h00, 8'h00};
        wr_tab[4] = '{1'b1, 8'hFF, 8'hFF};
        wr_tab[5] = '{1'b0, 8'h00, 8'hFF};

        // Reset held with busy inputs: everything must stay zero.
        reset     = 1'b0;
        pins_i    = 8'hFF;
        wr_en_i   = 1'b1;
        wr_data_i = 8'h5A;
        chg_clr_i = 1'b0;
        tick(2);
        expect_at(1, F_GPIO_O, 8'h00, "rst_gpio_o");
        expect_at(1, F_GPIO_I, 8'h00, "rst_gpio_i");
        expect_at(1, F_CHG,    8'h00, "rst_chg");
        expect_at(1, F_ANY,    8'h00, "rst_any");
        tick(1);
        pins_i    = 8'h00;
        wr_en_i   = 1'b0;
        wr_data_i = 8'h00;
        tick(1);
        reset = 1'b1;
        tick(1);

        // Output latch: load on wr_en_i, hold otherwise.
        for (int i = 0; i < 6; i++) begin
            wr_en_i   = wr_tab[i].we;
            wr_data_i = wr_tab[i].data;
            expect_at(1, F_GPIO_O, wr_tab[i].exp_out, $sformatf("wr_step%0d", i));
            tick(1);
        end
        wr_en_i = 1'b0;
        tick(2);

        // Held change on bit 0: visible exactly LAT edges after the change.
        pins_i = 8'h01;
        expect_at(LAT - 1, F_GPIO_I, 8'h00, "bit0_early");
        expect_at(LAT,     F_GPIO_I, 8'h01, "bit0_accept");
        expect_at(LAT - 1, F_CHG,    8'h00, "bit0_chg_early");
        expect_at(LAT,     F_CHG,    8'h01, "bit0_chg");
        expect_at(LAT - 1, F_ANY,    8'h00, "bit0_any_early");
        expect_at(LAT,     F_ANY,    8'h01, "bit0_any");
        tick(LAT + 2);

        // Bit 2 accepted on the same edge as a clear: set wins, bit 0 clears.
        pins_i = 8'h05;
        expect_at(LAT - 1, F_CHG,    8'h01, "bit0_flag_held");
        expect_at(LAT,     F_CHG,    8'h04, "set_wins_clr");
        expect_at(LAT,     F_GPIO_I, 8'h05, "bit2_accept");
        expect_at(LAT + 1, F_CHG,    8'h04, "flag_sticky");
        tick(LAT - 1);
        pulse_clr();
        tick(2);

        // Plain clear.
        expect_at(1, F_CHG, 8'h00, "clr_all");
        expect_at(1, F_ANY, 8'h00, "clr_any");
        pulse_clr();
        tick(1);

        // Several bits change at once in both directions.
        pins_i = 8'h5A;
        expect_at(LAT - 1, F_GPIO_I, 8'h05, "multi_early");
        expect_at(LAT,     F_GPIO_I, 8'h5A, "multi_accept");
        expect_at(LAT,     F_CHG,    8'h5F, "multi_chg");
        tick(LAT + 1);
        pulse_clr();
        pins_i = 8'h00;
        expect_at(1,   F_CHG,    8'h00, "clr_before_revert");
        expect_at(LAT, F_GPIO_I, 8'h00, "revert_accept");
        expect_at(LAT, F_CHG,    8'h5A, "revert_chg");
        tick(LAT + 1);
        pulse_clr();
        tick(1);

`ifdef GPIO_DEBOUNCE_EN
        // 3-cycle glitch on bit 3 with DC=4: one short of acceptance.
        pins_i = 8'h08;
        expect_at(4, F_GPIO_I, 8'h00, "glitch_mid");
        expect_at(6, F_GPIO_I, 8'h00, "glitch_gpio_i");
        expect_at(6, F_CHG,    8'h00, "glitch_chg");
        expect_at(9, F_GPIO_I, 8'h00, "glitch_gpio_i_late");
        expect_at(9, F_ANY,    8'h00, "glitch_any");
        tick(3);
        pins_i = 8'h00;
        tick(8);
`else
        // Single-cycle pulse passes straight through the synchronizer.
        pins_i = 8'hFF;
        expect_at(2, F_GPIO_I, 8'h00, "pulse_early");
        expect_at(3, F_GPIO_I, 8'hFF, "pulse_high");
        expect_at(4, F_GPIO_I, 8'h00, "pulse_low");
        expect_at(3, F_CHG,    8'hFF, "pulse_chg");
        expect_at(5, F_CHG,    8'hFF, "pulse_chg_sticky");
        tick(1);
        pins_i = 8'h00;
        tick(6);
        pulse_clr();
        tick(2);
`endif

        // Reset two counts before bit 7 would be accepted discards the progress.
        pins_i = 8'h80;
        tick(LAT - 2);
        reset = 1'b0;
        expect_at(1, F_GPIO_O, 8'h00, "mid_rst_gpio_o");
        expect_at(1, F_GPIO_I, 8'h00, "mid_rst_gpio_i");
        expect_at(1, F_CHG,    8'h00, "mid_rst_chg");
        expect_at(1, F_ANY,    8'h00, "mid_rst_any");
        tick(1);
        reset = 1'b1;
        expect_at(1,       F_GPIO_O, 8'h00, "post_rst_gpio_o");
        expect_at(LAT - 1, F_GPIO_I, 8'h00, "bit7_not_early");
        expect_at(LAT,     F_GPIO_I, 8'h80, "bit7_full_latency");
        expect_at(LAT,     F_CHG,    8'h80, "bit7_chg");
        tick(LAT + 2);

        for (int guard = 0; guard < 200 && sb_q.size() != 0; guard++) begin
            tick(1);
        end
        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb_q.size());
            $fatal(1, "scoreboard did not drain");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
